// File: rtl/csr_timer_intc.sv
// csr_timer_intc: ECFG/ESTAT/TID/TCFG/TVAL/TICLR timer and interrupt collection with stable counter.
module csr_timer_intc #(
  parameter int TIMER_W     = 32,
  parameter int HWI_N       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             csr_we,
  input  logic [13:0]      csr_waddr,
  input  logic [31:0]      csr_wmask,
  input  logic [31:0]      csr_wdata,
  input  logic [13:0]      csr_raddr,
  output logic [31:0]      csr_rdata,
  input  logic             crmd_ie,
  input  logic [HWI_N-1:0] hwi,
  input  logic             ipi,
  output logic             need_interrupt,
  output logic [63:0]      stable_cnt
);
  localparam logic [13:0] A_ECFG  = 14'h4;
  localparam logic [13:0] A_ESTAT = 14'h5;
  localparam logic [13:0] A_TID   = 14'h40;
  localparam logic [13:0] A_TCFG  = 14'h41;
  localparam logic [13:0] A_TVAL  = 14'h42;
  localparam logic [13:0] A_TICLR = 14'h44;

  function automatic logic [31:0] mw(input logic [31:0] o, input logic [31:0] d, input logic [31:0] m);
    return (o & ~m) | (d & m);
  endfunction

  logic [12:0]                     ecfg_q, ecfg_d;
  logic [1:0]                      swi_q, swi_d;
  logic                            ti_q, ti_d;
  logic [31:0]                     tid_q, tid_d;
  logic [TIMER_W-1:0]              tcfg_q, tcfg_d, tval_q, tval_d;
  logic [SYNC_STAGES-1:0][HWI_N:0] sync_q, sync_d;
  logic [63:0]                     cnt_q, cnt_d;
  logic [31:0]                     tcfg_new;
  logic [12:0]                     is_v;
  logic                            we_ecfg, we_estat, we_tid, we_tcfg, we_ticlr, fire;

  always_comb begin
    we_ecfg  = csr_we && csr_waddr == A_ECFG;
    we_estat = csr_we && csr_waddr == A_ESTAT;
    we_tid   = csr_we && csr_waddr == A_TID;
    we_tcfg  = csr_we && csr_waddr == A_TCFG;
    we_ticlr = csr_we && csr_waddr == A_TICLR;
    tcfg_new = mw(32'(tcfg_q), csr_wdata, csr_wmask);
    ecfg_d   = we_ecfg ? 13'(mw(32'(ecfg_q), csr_wdata, csr_wmask & 32'h1BFF)) : ecfg_q;
    swi_d    = we_estat ? 2'(mw(32'(swi_q), csr_wdata, csr_wmask)) : swi_q;
    tid_d    = we_tid ? mw(tid_q, csr_wdata, csr_wmask) : tid_q;
    tcfg_d   = we_tcfg ? TIMER_W'(tcfg_new) : tcfg_q;
    // a TCFG write overrides any count or fire happening on the same edge
    fire     = !we_tcfg && tcfg_q[0] && tval_q == TIMER_W'(1);
    tval_d   = we_tcfg        ? {tcfg_new[TIMER_W-1:2], 2'b00} :
               !tcfg_q[0]     ? tval_q :
               tval_q != '0   ? tval_q - TIMER_W'(1) :
               tcfg_q[1]      ? {tcfg_q[TIMER_W-1:2], 2'b00} : tval_q;
    ti_d     = fire | (ti_q & ~(we_ticlr & csr_wdata[0] & csr_wmask[0]));
    sync_d[0] = {ipi, hwi};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    cnt_d    = cnt_q + 64'd1;
    is_v             = '0;
    is_v[1:0]        = swi_q;
    is_v[2 +: HWI_N] = sync_q[SYNC_STAGES-1][HWI_N-1:0];
    is_v[11]         = ti_q;
    is_v[12]         = sync_q[SYNC_STAGES-1][HWI_N];
    csr_rdata = csr_raddr == A_ECFG  ? 32'(ecfg_q) :
                csr_raddr == A_ESTAT ? 32'(is_v) :
                csr_raddr == A_TID   ? tid_q :
                csr_raddr == A_TCFG  ? 32'(tcfg_q) :
                csr_raddr == A_TVAL  ? 32'(tval_q) : 32'h0;
    need_interrupt = crmd_ie & |(is_v & ecfg_q);
  end

  assign stable_cnt = cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ecfg_q <= '0;
      swi_q  <= '0;
      ti_q   <= 1'b0;
      tid_q  <= '0;
      tcfg_q <= '0;
      tval_q <= '0;
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      ecfg_q <= ecfg_d;
      swi_q  <= swi_d;
      ti_q   <= ti_d;
      tid_q  <= tid_d;
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_csr_timer_intc.sv
// tb_csr_timer_intc: directed checks of the timer/interrupt CSR block, plus a TIMER_W=12 instance.
module tb_csr_timer_intc;
  logic        clk = 1'b0, reset = 1'b0, csr_we = 1'b0, crmd_ie = 1'b0, ipi = 1'b0;
  logic [13:0] csr_waddr = '0, csr_raddr = '0;
  logic [31:0] csr_wmask = '0, csr_wdata = '0, csr_rdata, rdata_w;
  logic [7:0]  hwi = '0;
  logic        need_interrupt, need_w;
  logic [63:0] stable_cnt, cnt_w;
  int          checks = 0, errors = 0;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  always #5 clk = ~clk;

  csr_timer_intc dut (
    .clk(clk), .reset(reset), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wmask(csr_wmask),
    .csr_wdata(csr_wdata), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .crmd_ie(crmd_ie),
    .hwi(hwi), .ipi(ipi), .need_interrupt(need_interrupt), .stable_cnt(stable_cnt)
  );

  csr_timer_intc #(.TIMER_W(12)) u_w (
    .clk(clk), .reset(reset), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wmask(csr_wmask),
    .csr_wdata(csr_wdata), .csr_raddr(csr_raddr), .csr_rdata(rdata_w), .crmd_ie(crmd_ie),
    .hwi(hwi), .ipi(ipi), .need_interrupt(need_w), .stable_cnt(cnt_w)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [13:0] a, input logic [31:0] e);
    csr_raddr = a;
    #1;
    chk(tag, csr_rdata, e);
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
    csr_we = 1'b1; csr_waddr = a; csr_wdata = d; csr_wmask = m;
    tick();
    csr_we = 1'b0;
  endtask

  initial begin
    logic [13:0] addrs [6] = '{14'h4, 14'h5, 14'h40, 14'h41, 14'h42, 14'h44};
    #1;
    foreach (addrs[i]) rd($sformatf("reset_rd_%h", addrs[i]), addrs[i], 32'h0);
    chk("reset_need", need_interrupt, 1'b0);
    chk("reset_cnt", stable_cnt, 64'd0);
    tick(); tick();
    reset = 1'b1;
    repeat (5) tick();
    chk("cnt_after_5", stable_cnt, 64'd5);

    // one-shot timer
    crmd_ie = 1'b1;
    wr(14'h4, 32'h800, ONES);
    wr(14'h41, 32'h5, ONES);
    rd("os_tval4", 14'h42, 32'd4);
    rd("os_is_4", 14'h5, 32'h0);
    tick(); rd("os_tval3", 14'h42, 32'd3);
    tick(); rd("os_tval2", 14'h42, 32'd2);
    tick(); rd("os_tval1", 14'h42, 32'd1);
    rd("os_is_1", 14'h5, 32'h0);
    chk("os_need_1", need_interrupt, 1'b0);
    tick(); rd("os_tval0", 14'h42, 32'd0);
    rd("os_is_0", 14'h5, 32'h800);
    chk("os_need_0", need_interrupt, 1'b1);
    tick(); rd("os_tval_hold", 14'h42, 32'd0);
    wr(14'h44, 32'h1, ONES);
    rd("os_ticlr", 14'h5, 32'h0);
    chk("os_need_clr", need_interrupt, 1'b0);
    rd("ticlr_rd0", 14'h44, 32'h0);

    // periodic timer, TICLR races
    wr(14'h41, 32'h7, ONES);
    rd("per_tval4", 14'h42, 32'd4);
    tick(); tick(); tick();
    rd("per_tval1", 14'h42, 32'd1);
    wr(14'h44, 32'h1, ONES);
    rd("per_set_wins", 14'h5, 32'h800);
    rd("per_tval0", 14'h42, 32'd0);
    wr(14'h44, 32'h1, ONES);
    rd("per_clr", 14'h5, 32'h0);
    rd("per_reload", 14'h42, 32'd4);
    tick(); tick(); tick();
    rd("per_pre_fire", 14'h5, 32'h0);
    tick();
    rd("per_fire5", 14'h5, 32'h800);
    chk("per_need", need_interrupt, 1'b1);
    wr(14'h41, 32'h0, ONES);
    rd("stop_tval", 14'h42, 32'd0);

    // ESTAT write: only SW bits, cannot clear timer flag
    wr(14'h5, ONES, ONES);
    rd("estat_set", 14'h5, 32'h803);
    wr(14'h5, 32'h0, ONES);
    rd("estat_keep11", 14'h5, 32'h800);
    wr(14'h44, 32'h1, 32'h0);
    rd("ticlr_masked", 14'h5, 32'h800);
    wr(14'h44, 32'h1, ONES);
    rd("ticlr_clear", 14'h5, 32'h0);

    // TCFG write racing the 1->0 transition
    wr(14'h41, 32'h7, ONES);
    tick(); tick(); tick();
    rd("race_tval1", 14'h42, 32'd1);
    wr(14'h41, 32'hB, ONES);
    rd("race_reload", 14'h42, 32'd8);
    rd("race_no_fire", 14'h5, 32'h0);

    // InitVal=0 never fires; TVAL is read-only
    wr(14'h41, 32'h1, ONES);
    repeat (3) tick();
    rd("iv0_tval", 14'h42, 32'd0);
    rd("iv0_is", 14'h5, 32'h0);
    wr(14'h42, 32'h1234, ONES);
    rd("tval_ro", 14'h42, 32'd0);

    // masked ECFG write and bit 10 hardwired
    wr(14'h4, 32'h0, ONES);
    wr(14'h4, 32'h1FFF, 32'h0C03);
    rd("ecfg_mask", 14'h4, 32'h803);
    wr(14'h4, ONES, ONES);
    rd("ecfg_full", 14'h4, 32'h1BFF);
    rd("unmapped", 14'h123, 32'h0);

    // TID: same-cycle read returns old value
    csr_we = 1'b1; csr_waddr = 14'h40; csr_wdata = 32'hDEADBEEF; csr_wmask = ONES;
    rd("tid_old", 14'h40, 32'h0);
    tick(); csr_we = 1'b0;
    rd("tid_new", 14'h40, 32'hDEADBEEF);
    wr(14'h40, 32'h0, 32'hFFFF_0000);
    rd("tid_mask", 14'h40, 32'h0000_BEEF);

    // hardware line through 2-stage synchroniser
    wr(14'h4, 32'h20, ONES);
    for (int p = 0; p < 2; p++) begin
      crmd_ie = (p == 0);
      hwi[3] = 1'b1;
      for (int i = 1; i <= 7; i++) begin
        tick();
        if (i == 4) hwi[3] = 1'b0;
        rd($sformatf("hwi_is_p%0d_c%0d", p, i), 14'h5, (i >= 2 && i <= 5) ? 32'h20 : 32'h0);
        chk($sformatf("hwi_need_p%0d_c%0d", p, i), need_interrupt, (p == 0) && (i >= 2 && i <= 5));
      end
    end

    // ipi
    crmd_ie = 1'b1;
    ipi = 1'b1;
    tick();
    rd("ipi_1edge", 14'h5, 32'h0);
    tick();
    rd("ipi_2edge", 14'h5, 32'h1000);
    chk("ipi_unmasked", need_interrupt, 1'b0);
    wr(14'h4, 32'h1000, ONES);
    chk("ipi_need", need_interrupt, 1'b1);

    // timer width parameter
    wr(14'h41, ONES, ONES);
    csr_raddr = 14'h41; #1;
    chk("w12_tcfg", rdata_w, 32'h0000_0FFF);
    chk("w32_tcfg", csr_rdata, ONES);
    csr_raddr = 14'h42; #1;
    chk("w12_tval", rdata_w, 32'h0000_0FFC);
    chk("w32_tval", csr_rdata, 32'hFFFF_FFFC);

    // asynchronous reset mid-count
    #1 reset = 1'b0;
    #1;
    chk("arst_need", need_interrupt, 1'b0);
    chk("arst_cnt", stable_cnt, 64'd0);
    foreach (addrs[i]) rd($sformatf("arst_rd_%h", addrs[i]), addrs[i], 32'h0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("cnt_after_3", stable_cnt, 64'd3);
    rd("post_rst_tval", 14'h42, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
